// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: opcode classes, funct codes, state/select encodings and control decode shared by the sequencer and the datapath decoder
package kgp_risc_pkg;
    localparam int KGP_OPC_W = 6;
    localparam int KGP_FUNC_W = 5;
    localparam int KGP_MEM_TMO = 15;

    localparam logic [KGP_OPC_W-1:0] OPC_ALU_R = 6'b000000;
    localparam logic [KGP_OPC_W-1:0] OPC_ALU_I = 6'b000001;
    localparam logic [KGP_OPC_W-1:0] OPC_LW = 6'b000010;
    localparam logic [KGP_OPC_W-1:0] OPC_SW = 6'b000011;
    localparam logic [KGP_OPC_W-1:0] OPC_UNCOND = 6'b000100;
    localparam logic [KGP_OPC_W-1:0] OPC_COND = 6'b000101;
    localparam logic [KGP_OPC_W-1:0] OPC_HALT = 6'b111111;

    localparam logic [KGP_FUNC_W-1:0] FN_B = 5'd0;
    localparam logic [KGP_FUNC_W-1:0] FN_BL = 5'd1;
    localparam logic [KGP_FUNC_W-1:0] FN_BR = 5'd2;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR} state_t;
    typedef enum logic [1:0] {PC_SEQ, PC_BRT, PC_REG} pc_sel_t;
    typedef enum logic [1:0] {WS_ALU, WS_MEM, WS_LINK} rf_wsel_t;

    typedef struct packed {
        logic ir_we;
        logic pc_we;
        pc_sel_t pc_sel;
        logic alu_imm;
        logic rf_we;
        rf_wsel_t rf_wsel;
        logic dmem_req;
        logic dmem_we;
        logic halted;
        logic err;
    } ctrl_t;

    function automatic logic opc_legal(input logic [KGP_OPC_W-1:0] opc);
        return opc inside {OPC_ALU_R, OPC_ALU_I, OPC_LW, OPC_SW, OPC_UNCOND, OPC_COND, OPC_HALT};
    endfunction

    // Moore control word for a state; the COND branch enable is added by the caller from br_cond
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [KGP_OPC_W-1:0] opc, input logic [KGP_FUNC_W-1:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_we = 1'b1;
                c.pc_we = 1'b1;
            end
            S_EXEC: begin
                c.alu_imm = opc inside {OPC_ALU_I, OPC_LW, OPC_SW};
                if (opc == OPC_UNCOND) begin
                    c.pc_we = 1'b1;
                    c.pc_sel = (fn == FN_BR) ? PC_REG : PC_BRT;
                    c.rf_we = (fn == FN_BL);
                    c.rf_wsel = (fn == FN_BL) ? WS_LINK : WS_ALU;
                end
                if (opc == OPC_COND) c.pc_sel = PC_BRT;
            end
            S_MEM: begin
                c.dmem_req = 1'b1;
                c.dmem_we = (opc == OPC_SW);
            end
            S_WB: begin
                c.rf_we = 1'b1;
                c.rf_wsel = (opc == OPC_LW) ? WS_MEM : WS_ALU;
            end
            S_HALT: c.halted = 1'b1;
            S_ERR: c.err = 1'b1;
            default: ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/kgp_risc_seq_ctrl_if.sv
// kgp_risc_seq_ctrl_if: data-memory request/acknowledge handshake between sequencer and memory
interface kgp_risc_seq_ctrl_if;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    modport master (output dmem_req, output dmem_we, input dmem_ack);
    modport slave (input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/kgp_seq_mem_tmo.sv
// kgp_seq_mem_tmo: counts unacknowledged request cycles and flags the cycle the count would reach MEM_TMO
module kgp_seq_mem_tmo #(
    parameter int MEM_TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_ack,
    output logic o_timeout
);
    logic [3:0] r_cnt;

    assign o_timeout = i_req && !i_ack && (r_cnt == 4'(MEM_TMO - 1));

    // any ack or idle cycle restarts the count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= (i_req && !i_ack) ? r_cnt + 4'd1 : '0;
endmodule

// File: rtl/kgp_risc_seq_ctrl.sv
// kgp_risc_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; define KGP_SEQ_PERF_CNT_EN for cycle/instruction counters
module kgp_risc_seq_ctrl
    import kgp_risc_pkg::*;
#(
    parameter int OPC_W = KGP_OPC_W,
    parameter int FUNC_W = KGP_FUNC_W,
    parameter int MEM_TMO = KGP_MEM_TMO
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [FUNC_W-1:0] i_funct,
    input  logic              i_br_cond,
    kgp_risc_seq_ctrl_if.master dmem,
    output logic              o_ir_we,
    output logic              o_pc_we,
    output logic [1:0]        o_pc_sel,
    output logic              o_alu_imm,
    output logic              o_rf_we,
    output logic [1:0]        o_rf_wsel,
    output logic              o_halted,
    output logic              o_err
`ifdef KGP_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       o_cyc_cnt,
    output logic [31:0]       o_instr_cnt
`endif
);
    state_t r_state, w_next;
    logic [OPC_W-1:0] r_opc, w_opc;
    logic [FUNC_W-1:0] r_fn, w_fn;
    ctrl_t r_ctrl, w_ctrl;
    logic w_timeout;

    kgp_seq_mem_tmo #(.MEM_TMO(MEM_TMO)) u_tmo (
        .clk(clk),
        .rst_n(rst_n),
        .i_req(r_ctrl.dmem_req),
        .i_ack(dmem.dmem_ack),
        .o_timeout(w_timeout)
    );

    // outputs for EXEC are decoded from the IR fields being latched this cycle
    assign w_opc = (r_state == S_DECODE) ? i_opcode : r_opc;
    assign w_fn = (r_state == S_DECODE) ? i_funct : r_fn;
    assign w_ctrl = ctrl_decode(w_next, w_opc, w_fn);

    // next state; HALT and ERR hold until reset
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: w_next = !opc_legal(i_opcode) ? S_ERR : (i_opcode == OPC_HALT) ? S_HALT : S_EXEC;
            S_EXEC: w_next = (r_opc inside {OPC_LW, OPC_SW}) ? S_MEM : (r_opc inside {OPC_ALU_R, OPC_ALU_I}) ? S_WB : S_FETCH;
            S_MEM: w_next = dmem.dmem_ack ? ((r_opc == OPC_LW) ? S_WB : S_FETCH) : w_timeout ? S_ERR : S_MEM;
            S_WB: w_next = S_FETCH;
            default: w_next = r_state;
        endcase
    end

    // state, latched IR fields and registered control word; reset forces the FETCH word
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_opc <= '0;
            r_fn <= '0;
            r_ctrl <= ctrl_decode(S_FETCH, '0, '0);
        end else begin
            r_state <= w_next;
            r_ctrl <= w_ctrl;
            if (r_state == S_DECODE) begin
                r_opc <= i_opcode;
                r_fn <= i_funct;
            end
        end

    // pc_we is held low while reset is asserted so the first PC update lands on the first edge after release
    assign o_pc_we = (r_ctrl.pc_we && rst_n) || (r_state == S_EXEC && r_opc == OPC_COND && i_br_cond);
    assign o_ir_we = r_ctrl.ir_we;
    assign o_pc_sel = r_ctrl.pc_sel;
    assign o_alu_imm = r_ctrl.alu_imm;
    assign o_rf_we = r_ctrl.rf_we;
    assign o_rf_wsel = r_ctrl.rf_wsel;
    assign o_halted = r_ctrl.halted;
    assign o_err = r_ctrl.err;
    assign dmem.dmem_req = r_ctrl.dmem_req;
    assign dmem.dmem_we = r_ctrl.dmem_we;

`ifdef KGP_SEQ_PERF_CNT_EN
    logic [31:0] r_cyc_cnt, r_instr_cnt;

    // cycles spent running and completed returns to FETCH, both free-wrapping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cyc_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (!(r_state inside {S_HALT, S_ERR})) r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_next == S_FETCH && r_state != S_FETCH) r_instr_cnt <= r_instr_cnt + 32'd1;
        end

    assign o_cyc_cnt = r_cyc_cnt;
    assign o_instr_cnt = r_instr_cnt;
`endif
endmodule

// File: tb/tb_kgp_risc_seq_ctrl.sv
// tb_kgp_risc_seq_ctrl: per-cycle trace check of the sequencer against an instruction-level model
module tb_kgp_risc_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [4:0] funct = '0;
    logic br_cond = 1'b0;
    logic ir_we, pc_we, alu_imm, rf_we, halted, err;
    logic [1:0] pc_sel, rf_wsel;
    logic [11:0] obs;
    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [11:0] V_FETCH = 12'b1100_0000_0000;
    localparam logic [11:0] V_RST = 12'b1000_0000_0000;
    localparam logic [11:0] V_HALT = 12'b0000_0000_0010;
    localparam logic [11:0] V_ERR = 12'b0000_0000_0001;

    typedef struct {
        logic [5:0] opc;
        logic [4:0] fn;
        logic brc;
        logic ack;
        logic [11:0] exp;
    } cyc_t;
    cyc_t q[$];

    kgp_risc_seq_ctrl_if dif();

    kgp_risc_seq_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_opcode(opcode),
        .i_funct(funct),
        .i_br_cond(br_cond),
        .dmem(dif),
        .o_ir_we(ir_we),
        .o_pc_we(pc_we),
        .o_pc_sel(pc_sel),
        .o_alu_imm(alu_imm),
        .o_rf_we(rf_we),
        .o_rf_wsel(rf_wsel),
        .o_halted(halted),
        .o_err(err)
    );

    always #5 clk = ~clk;

    assign obs = {ir_we, pc_we, pc_sel, alu_imm, rf_we, rf_wsel, dif.dmem_req, dif.dmem_we, halted, err};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [11:0] v(input logic pw, input logic [1:0] ps, input logic imm, input logic rw,
                                      input logic [1:0] ws, input logic rq, input logic wq);
        return {1'b0, pw, ps, imm, rw, ws, rq, wq, 2'b00};
    endfunction

    function automatic void push(input logic [5:0] opc, input logic [4:0] fn, input logic brc, input logic ack, input logic [11:0] e);
        cyc_t c;
        c.opc = opc;
        c.fn = fn;
        c.brc = brc;
        c.ack = ack;
        c.exp = e;
        q.push_back(c);
    endfunction

    // one instruction as a cycle list: ack arrives after wt idle MEM cycles, wt >= 15 never acks
    function automatic void plan(input logic [5:0] opc, input logic [4:0] fn, input logic brc, input int wt);
        logic is_mem, legal, bl;
        is_mem = (opc == 6'd2) || (opc == 6'd3);
        legal = (opc <= 6'd5) || (opc == 6'h3f);
        bl = (fn == 5'd1);
        push(6'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), V_FETCH);
        push(opc, fn, 1'($urandom), 1'($urandom), '0);
        if (!legal || opc == 6'h3f) begin
            for (int i = 0; i < 4; i++) push(opc, fn, 1'($urandom), 1'($urandom), legal ? V_HALT : V_ERR);
            return;
        end
        case (opc)
            6'd0: push(opc, fn, brc, 1'($urandom), '0);
            6'd1, 6'd2, 6'd3: push(opc, fn, brc, 1'($urandom), v(0, 2'd0, 1, 0, 2'd0, 0, 0));
            6'd4: push(opc, fn, brc, 1'($urandom), v(1, fn == 5'd2 ? 2'd2 : 2'd1, 0, bl, bl ? 2'd2 : 2'd0, 0, 0));
            default: push(opc, fn, brc, 1'($urandom), v(brc, 2'd1, 0, 0, 2'd0, 0, 0));
        endcase
        if (is_mem) begin
            for (int k = 0; k < 15 && k <= wt; k++) push(opc, fn, 1'($urandom), k == wt, v(0, 2'd0, 0, 0, 2'd0, 1, opc == 6'd3));
            if (wt >= 15) begin
                for (int i = 0; i < 4; i++) push(opc, fn, 1'($urandom), 1'($urandom), V_ERR);
                return;
            end
        end
        if (opc <= 6'd2) push(opc, fn, 1'($urandom), 1'($urandom), v(0, 2'd0, 0, 1, opc == 6'd2 ? 2'd1 : 2'd0, 0, 0));
    endfunction

    task automatic drive(input cyc_t c);
        opcode = c.opc;
        funct = c.fn;
        br_cond = c.brc;
        dif.dmem_ack = c.ack;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dif.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        dif.dmem_ack = 1'b0;
        repeat (2) begin
            opcode = 6'($urandom);
            br_cond = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (obs !== V_RST) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b want %b", obs, V_RST);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        cyc_t c;
        plan(6'd0, 5'($urandom), 1'b0, 0);
        plan(6'd1, 5'($urandom), 1'b1, 0);
        plan(6'd0, 5'($urandom), 1'b1, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL alu_trace: opc %0d got %b want %b", c.opc, obs, c.exp);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        cyc_t c;
        plan(6'd5, 5'd0, 1'b0, 0);
        plan(6'd5, 5'd0, 1'b1, 0);
        plan(6'd4, 5'd0, 1'b0, 0);
        plan(6'd4, 5'd1, 1'b1, 0);
        plan(6'd4, 5'd2, 1'b0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL branch_trace: opc %0d fn %0d brc %0b got %b want %b", c.opc, c.fn, c.brc, obs, c.exp);
            end
            tick();
        end
    endtask

    task automatic test_mem();
        cyc_t c;
        plan(6'd2, 5'd0, 1'b0, 3);
        plan(6'd2, 5'd0, 1'b1, 0);
        plan(6'd3, 5'd0, 1'b0, 0);
        plan(6'd3, 5'd0, 1'b1, 5);
        plan(6'd2, 5'd0, 1'b0, 14);
        plan(6'd3, 5'd0, 1'b0, 14);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL mem_trace: opc %0d ack %0b got %b want %b", c.opc, c.ack, obs, c.exp);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        int k;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            case (k)
                0, 1, 2, 3: plan(6'(k), 5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2));
                4, 5, 6: plan(6'd4, 5'(k - 4), 1'($urandom), 0);
                default: plan(6'd5, 5'($urandom), 1'($urandom), 0);
            endcase
        end
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL random_trace: opc %0d fn %0d brc %0b ack %0b got %b want %b", c.opc, c.fn, c.brc, c.ack, obs, c.exp);
            end
            tick();
        end
    endtask

    task automatic test_sticky(input logic [5:0] opc, input int wt);
        cyc_t c;
        plan(opc, 5'd0, 1'b0, wt);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL sticky_trace: opc %0d got %b want %b", opc, obs, c.exp);
            end
            tick();
        end
        do_reset();
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c;
        plan(6'd2, 5'd0, 1'b0, 20);
        for (int i = 0; i < 5; i++) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL midrst_pre: cyc %0d got %b want %b", i, obs, c.exp);
            end
            if (i < 4) tick();
        end
        q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== V_RST) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want %b", obs, V_RST);
        end
        tick();
        rst_n = 1'b1;
        plan(6'd0, 5'd0, 1'b0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            n_cmp++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL midrst_restart: got %b want %b", obs, c.exp);
            end
            tick();
        end
    endtask

    initial begin
        dif.dmem_ack = 1'b0;
        #1;
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_back_to_back();
        test_sticky(6'h3f, 0);
        test_sticky(6'b001010, 0);
        test_sticky(6'd3, 15);
        test_sticky(6'd2, 15);
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
